// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, instruction width
// and the bubble word loaded into IF/ID when no real instruction is issued.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] BUBBLE = 32'h0000_0000;

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush has priority over load; otherwise hold.
module if_id_reg
  import mips_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [31:0]        pc_plus4,
  output logic [INSTR_W-1:0] if_id_instruction,
  output logic [31:0]        if_id_pc_plus4,
  output logic               if_id_valid
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_id_instruction <= BUBBLE;
      if_id_pc_plus4    <= 32'h0;
      if_id_valid       <= 1'b0;
    end else if (flush) begin
      if_id_instruction <= BUBBLE;
      if_id_pc_plus4    <= 32'h0;
      if_id_valid       <= 1'b0;
    end else if (load) begin
      if_id_instruction <= instruction;
      if_id_pc_plus4    <= pc_plus4;
      if_id_valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, START/RUN/HALT sequencing, issue counter,
// and the IF/ID register. imem_addr is the PC register itself.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int          IMEM_BYTES = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic [INSTR_W-1:0] if_id_instruction,
  output logic [31:0]        if_id_pc_plus4,
  output logic               if_id_valid,
  output logic               halted,
  output logic [31:0]        fetch_count,
  output fetch_state_e       fsm_state
);

  localparam logic [31:0] MEM_LIMIT = 32'(IMEM_BYTES);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  target_aligned;
  logic         target_in_range;
  logic         at_end;
  logic         redirect;
  logic         issue;
  logic         flush;

  assign pc_plus4        = pc + 32'd4;
  assign target_aligned  = {branch_target[31:2], 2'b00};
  assign target_in_range = (branch_target + 32'd4) <= MEM_LIMIT;
  assign at_end          = pc_plus4 >= MEM_LIMIT;

  // Redirect beats stall; START ignores both control inputs.
  assign redirect = branch_taken && (state != START);
  assign issue    = (state == RUN) && !branch_taken && !stall;
  assign flush    = (state == START) || redirect || ((state == HALT) && !stall);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= START;
      halted      <= 1'b0;
      pc          <= RESET_PC;
      fetch_count <= 32'h0;
    end else begin
      case (state)
        START: begin
          state  <= RUN;
          halted <= 1'b0;
        end
        RUN, HALT: begin
          if (redirect) begin
            pc     <= target_aligned;
            state  <= target_in_range ? RUN : HALT;
            halted <= !target_in_range;
          end else if (issue) begin
            fetch_count <= fetch_count + 32'd1;
            // The last word is still issued; the PC parks on it.
            if (at_end) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        default: begin
          state  <= START;
          halted <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = pc;
  assign fsm_state = state;

  if_id_reg u_if_id_reg (
    .clock             (clock),
    .reset             (reset),
    .load              (issue),
    .flush             (flush),
    .instruction       (imem_instruction),
    .pc_plus4          (pc_plus4),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_valid       (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural model checked every cycle plus
// hand-computed literal expectations for each scenario.
module tb_fetch_stage;
  import mips_pkg::*;

  localparam int MEM_WORDS = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         stall = 1'b0;
  logic         branch_taken = 1'b0;
  logic [31:0]  branch_target = 32'h0;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_instruction;
  logic [31:0]  if_id_instruction;
  logic [31:0]  if_id_pc_plus4;
  logic         if_id_valid;
  logic         halted;
  logic [31:0]  fetch_count;
  fetch_state_e fsm_state;

  logic [31:0] mem [MEM_WORDS];

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(.IMEM_BYTES(64), .RESET_PC(32'h0)) dut (
    .clock             (clock),
    .reset             (reset),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .imem_addr         (imem_addr),
    .imem_instruction  (imem_instruction),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_valid       (if_id_valid),
    .halted            (halted),
    .fetch_count       (fetch_count),
    .fsm_state         (fsm_state)
  );

  // ---- clock ----
  always #5 clock = ~clock;

  // ---- instruction memory: word i holds A000_0000 + i ----
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'hA000_0000 + 32'(i);
  end
  assign imem_instruction = mem[imem_addr[5:2]];

  // ---- behavioural model ----
  logic [31:0] m_pc, m_instr, m_pp4, m_count;
  logic        m_valid, m_started, m_halted;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
      m_count = 32'h0; m_started = 1'b0; m_halted = 1'b0;
    end else if (!m_started) begin
      m_started = 1'b1;
      m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    end else if (branch_taken) begin
      m_pc = branch_target & 32'hFFFF_FFFC;
      m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
      m_halted = !((branch_target + 32'd4) <= 32'd64);
    end else if (stall) begin
      // everything holds
    end else if (m_halted) begin
      m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
    end else begin
      m_instr = mem[m_pc[5:2]];
      m_pp4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_count = m_count + 32'd1;
      if (m_pc + 32'd4 >= 32'd64) m_halted = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- per-cycle compare against the model ----
  always @(negedge clock) begin
    if (!reset) begin
      chk("model_imem_addr", imem_addr, m_pc);
      chk("model_instr", if_id_instruction, m_instr);
      chk("model_pc_plus4", if_id_pc_plus4, m_pp4);
      chk("model_valid", 32'(if_id_valid), 32'(m_valid));
      chk("model_halted", 32'(halted), 32'(m_halted));
      chk("model_count", fetch_count, m_count);
    end
  end

  // ---- driver tasks: inputs change 2 time units after the rising edge ----
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    cycles(1);
    reset = 1'b0;
  endtask

  task automatic set_ctl(input logic s, input logic b, input logic [31:0] t);
    stall = s; branch_taken = b; branch_target = t;
  endtask

  // ---- directed scenarios ----
  initial begin
    #1;
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_valid", 32'(if_id_valid), 32'h0);
    chk("reset_count", fetch_count, 32'h0);
    do_reset();

    // START cycle: bubble, PC held at 0
    cycles(1);
    chk("start_valid", 32'(if_id_valid), 32'h0);
    chk("start_addr", imem_addr, 32'h0);

    // straight-line fetch of five words
    for (int k = 0; k < 5; k++) begin
      cycles(1);
      chk("line_instr", if_id_instruction, 32'hA000_0000 + 32'(k));
      chk("line_pp4", if_id_pc_plus4, 32'(4 * (k + 1)));
      chk("line_valid", 32'(if_id_valid), 32'h1);
    end
    chk("line_count", fetch_count, 32'd5);
    chk("line_addr", imem_addr, 32'd20);

    // stall at PC=8
    do_reset();
    cycles(3);
    chk("pre_stall_addr", imem_addr, 32'd8);
    set_ctl(1'b1, 1'b0, 32'h0);
    cycles(2);
    chk("stall_addr", imem_addr, 32'd8);
    chk("stall_instr", if_id_instruction, 32'hA000_0001);
    chk("stall_count", fetch_count, 32'd2);
    set_ctl(1'b0, 1'b0, 32'h0);
    cycles(1);
    chk("post_stall_addr", imem_addr, 32'd12);
    chk("post_stall_instr", if_id_instruction, 32'hA000_0002);

    // redirect with stall at PC=12, unaligned target
    set_ctl(1'b1, 1'b1, 32'h0000_0002);
    cycles(1);
    set_ctl(1'b0, 1'b0, 32'h0);
    chk("redir_addr", imem_addr, 32'd0);
    chk("redir_valid", 32'(if_id_valid), 32'h0);
    chk("redir_count", fetch_count, 32'd3);
    cycles(1);
    chk("redir_next_instr", if_id_instruction, 32'hA000_0000);
    chk("redir_next_pp4", if_id_pc_plus4, 32'd4);
    chk("redir_next_count", fetch_count, 32'd4);

    // run to the end of memory
    cycles(14);
    chk("end_pc60", imem_addr, 32'd60);
    chk("end_pre_halted", 32'(halted), 32'h0);
    cycles(1);
    chk("end_last_instr", if_id_instruction, 32'hA000_000F);
    chk("end_last_pp4", if_id_pc_plus4, 32'd64);
    chk("end_halted", 32'(halted), 32'h1);
    chk("end_addr_hold", imem_addr, 32'd60);
    chk("end_count", fetch_count, 32'd19);
    cycles(2);
    chk("end_bubble", 32'(if_id_valid), 32'h0);
    chk("end_addr_hold2", imem_addr, 32'd60);
    set_ctl(1'b0, 1'b1, 32'h0);
    cycles(1);
    set_ctl(1'b0, 1'b0, 32'h0);
    chk("resume_halted", 32'(halted), 32'h0);
    chk("resume_addr", imem_addr, 32'd0);
    cycles(1);
    chk("resume_instr", if_id_instruction, 32'hA000_0000);
    chk("resume_count", fetch_count, 32'd20);

    // out-of-range redirect
    set_ctl(1'b0, 1'b1, 32'd64);
    cycles(1);
    set_ctl(1'b0, 1'b0, 32'h0);
    chk("oor_halted", 32'(halted), 32'h1);
    chk("oor_valid", 32'(if_id_valid), 32'h0);
    cycles(1);
    chk("oor_still_halted", 32'(halted), 32'h1);
    chk("oor_count", fetch_count, 32'd20);

    // back in range, then asynchronous reset between edges at PC=20
    set_ctl(1'b0, 1'b1, 32'd16);
    cycles(1);
    set_ctl(1'b0, 1'b0, 32'h0);
    cycles(1);
    chk("pre_areset_addr", imem_addr, 32'd20);
    #1;
    reset = 1'b1;
    #1;
    chk("areset_addr", imem_addr, 32'h0);
    chk("areset_valid", 32'(if_id_valid), 32'h0);
    chk("areset_count", fetch_count, 32'h0);
    chk("areset_halted", 32'(halted), 32'h0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    cycles(3);
    chk("after_reset_instr", if_id_instruction, 32'hA000_0001);
    chk("after_reset_count", fetch_count, 32'd2);

    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
